// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - instruction issue stage: FIFO, instruction register, decode and controller handshake
// The FIFO and the issue sequencer live in this one file; the FIFO carries control state only under reset.

module instr_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
endmodule

module instr_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        waiting,
  output logic        start,
  output logic [2:0]  opcode,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        busy,
  output logic        illegal,
  output logic [7:0]  issued_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE_WAIT} state_t;

  state_t      state;
  logic [15:0] ir;
  logic [15:0] head_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        head_legal;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  // A pop happens whenever the sequencer is ready for the next word: from IDLE, or
  // on the completion edge of the current instruction.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == DONE_WAIT) && waiting));

  assign head_legal = (head_data[15:13] == 3'b101) || (head_data[15:13] == 3'b110);

  instr_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_instr),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ir           <= '0;
      illegal      <= 1'b0;
      issued_count <= '0;
    end else begin
      illegal <= pop && !head_legal;
      if (pop) ir <= head_data;
      case (state)
        IDLE: begin
          if (pop && head_legal) state <= ISSUE;
        end
        ISSUE: begin
          if (waiting) state <= RUN;
        end
        RUN: begin
          if (!waiting) state <= DONE_WAIT;
        end
        DONE_WAIT: begin
          if (waiting) begin
            issued_count <= issued_count + 8'd1;
            state        <= (pop && head_legal) ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start = (state == ISSUE) && waiting;
  assign busy  = (state != IDLE);

  assign opcode   = ir[15:13];
  assign ALU_op   = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign shift_op = ir[4:3];
  assign rm       = ir[2:0];
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};
  assign sximm5   = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - randomized self-checking bench for instr_issue with a behavioural controller
// Expected issue order, drops and counts come from a queue model of pushed words.

module tb_instr_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        waiting;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  ALU_op;
  logic [1:0]  shift_op;
  logic [2:0]  rn, rd, rm;
  logic [15:0] sximm8, sximm5;
  logic        busy;
  logic        illegal;
  logic [7:0]  issued_count;

  int total = 0;
  int bad   = 0;

  int start_cycles   = 0;
  int illegal_cycles = 0;
  int accepts        = 0;
  int stable_err     = 0;
  int busy_cfg       = 4;
  bit rand_busy      = 1'b0;
  int ctrl_left      = 0;
  int exp_count      = 0;
  logic [15:0] held;
  logic [15:0] obs_word_q[$];
  logic [15:0] obs_imm8_q[$];
  logic [15:0] obs_imm5_q[$];
  logic [15:0] exp_q[$];

  instr_issue #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .waiting      (waiting),
    .start        (start),
    .opcode       (opcode),
    .ALU_op       (ALU_op),
    .shift_op     (shift_op),
    .rn           (rn),
    .rd           (rd),
    .rm           (rm),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .busy         (busy),
    .illegal      (illegal),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ir_view();
    return {opcode, ALU_op, rn, rd, shift_op, rm};
  endfunction

  function automatic logic [15:0] ref_sx8(input logic [15:0] w);
    int v;
    v = int'(w) % 256;
    if (v >= 128) v = v + 65280;
    return 16'(v);
  endfunction

  function automatic logic [15:0] ref_sx5(input logic [15:0] w);
    int v;
    v = int'(w) % 32;
    if (v >= 16) v = v + 65504;
    return 16'(v);
  endfunction

  function automatic bit ref_legal(input logic [15:0] w);
    int op;
    op = int'(w) / 8192;
    return (op == 5) || (op == 6);
  endfunction

  // Controller model: samples start at a rising edge, then is busy for a number of cycles.
  initial begin
    logic s;
    waiting = 1'b1;
    forever begin
      @(negedge clk);
      s = start;
      if (start)   start_cycles++;
      if (illegal) illegal_cycles++;
      if (ctrl_left > 0 && busy && ir_view() !== held) stable_err++;
      @(posedge clk);
      #1;
      if (ctrl_left > 0) begin
        ctrl_left--;
        if (ctrl_left == 0) waiting = 1'b1;
      end else if (s) begin
        accepts++;
        held = ir_view();
        obs_word_q.push_back(held);
        obs_imm8_q.push_back(sximm8);
        obs_imm5_q.push_back(sximm5);
        ctrl_left = rand_busy ? int'($urandom_range(1, 5)) : busy_cfg;
        waiting = 1'b0;
      end
    end
  end

  task automatic push(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready stuck at %0b, need 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ref_legal(w)) exp_q.push_back(w);
  endtask

  task automatic wait_idle();
    int n, run;
    n = 0;
    run = 0;
    while (run < 6 && n < 20000) begin
      @(negedge clk);
      n++;
      if (!busy && waiting && !illegal) run++;
      else run = 0;
    end
    if (run < 6) begin
      total++; bad++;
      $display("FAIL drain_timeout: busy=%0b, need idle", busy);
    end
  endtask

  task automatic clear_logs();
    obs_word_q.delete();
    obs_imm8_q.delete();
    obs_imm5_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (start !== 1'b0)    begin bad++; $display("FAIL rst_start: got %0b want 0", start); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (illegal !== 1'b0)  begin bad++; $display("FAIL rst_illegal: got %0b want 0", illegal); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    total++; if (issued_count !== 8'h00) begin bad++; $display("FAIL rst_count: got %0h want 0", issued_count); end
    total++; if (ir_view() !== 16'h0) begin bad++; $display("FAIL rst_fields: got %0h want 0", ir_view()); end
    total++; if (sximm8 !== 16'h0 || sximm5 !== 16'h0) begin bad++; $display("FAIL rst_imm: got %0h/%0h want 0/0", sximm8, sximm5); end
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset_traffic();
    int s0, n;
    clear_logs();
    rand_busy = 1'b0;
    busy_cfg = 20;
    s0 = start_cycles;
    push(16'hA123);
    n = 0;
    while (ctrl_left == 0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rt_running: busy got %0b want 1", busy); end
    rst = 1'b1;
    #1;
    total++; if (start !== 1'b0)    begin bad++; $display("FAIL rt_start: got %0b want 0", start); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rt_busy: got %0b want 0", busy); end
    total++; if (issued_count !== 8'h00) begin bad++; $display("FAIL rt_count: got %0h want 0", issued_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rt_in_ready: got %0b want 1", in_ready); end
    total++; if (opcode !== 3'b000) begin bad++; $display("FAIL rt_opcode: got %0h want 0", opcode); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (start_cycles - s0 !== 1) begin bad++; $display("FAIL rt_starts: got %0d want 1", start_cycles - s0); end
    total++; if (issued_count !== 8'h00) begin bad++; $display("FAIL rt_count_after: got %0h want 0", issued_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rt_busy_after: got %0b want 0", busy); end
    exp_count = 0;
  endtask

  task automatic test_add();
    int s0, e0;
    logic [15:0] w;
    clear_logs();
    busy_cfg = 4;
    s0 = start_cycles;
    e0 = stable_err;
    push(16'b101_00_001_010_00_011);
    exp_count++;
    wait_idle();
    total++; if (start_cycles - s0 !== 1) begin bad++; $display("FAIL add_start_cycles: got %0d want 1", start_cycles - s0); end
    total++; if (issued_count !== 8'(exp_count)) begin bad++; $display("FAIL add_count: got %0d want %0d", issued_count, exp_count); end
    total++; if (stable_err - e0 !== 0) begin bad++; $display("FAIL add_held: got %0d changes want 0", stable_err - e0); end
    total++;
    if (obs_word_q.size() !== 1) begin
      bad++; $display("FAIL add_issued: got %0d words want 1", obs_word_q.size());
    end else begin
      w = obs_word_q[0];
      if (w[15:13] !== 3'd5 || w[10:8] !== 3'd1 || w[7:5] !== 3'd2 || w[2:0] !== 3'd3) begin
        bad++; $display("FAIL add_fields: got %0h want a143", w);
      end
    end
  endtask

  task automatic test_mov();
    int n, ts, tb;
    logic [15:0] imm;
    clear_logs();
    busy_cfg = 1;
    ts = -1;
    tb = -1;
    imm = 16'h0;
    push(16'hD2F0);
    exp_count++;
    n = 0;
    while (tb < 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (start && ts < 0) begin ts = n; imm = sximm8; end
      else if (ts >= 0 && !busy) tb = n;
    end
    total++; if (ts !== 2) begin bad++; $display("FAIL mov_latency: start at cycle %0d want 2", ts); end
    total++; if (tb - ts !== 3) begin bad++; $display("FAIL mov_busy_drop: got %0d want 3", tb - ts); end
    total++; if (imm !== 16'hFFF0) begin bad++; $display("FAIL mov_sximm8: got %0h want fff0", imm); end
    total++; if (rn !== 3'd2) begin bad++; $display("FAIL mov_rn: got %0d want 2", rn); end
    wait_idle();
    total++; if (issued_count !== 8'(exp_count)) begin bad++; $display("FAIL mov_count: got %0d want %0d", issued_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    int s0, n;
    clear_logs();
    busy_cfg = 30;
    s0 = start_cycles;
    push(16'hA001);
    n = 0;
    while (ctrl_left == 0 && n < 50) begin @(negedge clk); n++; end
    push(16'hA802);
    push(16'hC403);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: in_ready got %0b want 0", in_ready); end
    in_valid = 1'b1;
    in_instr = 16'hA0E4;
    n = 0;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(16'hA0E4);
    total++; if (n < 10) begin bad++; $display("FAIL bp_blocked: waited %0d cycles want >=10", n); end
    exp_count += 4;
    wait_idle();
    total++; if (start_cycles - s0 !== 4) begin bad++; $display("FAIL bp_starts: got %0d want 4", start_cycles - s0); end
    total++; if (issued_count !== 8'(exp_count)) begin bad++; $display("FAIL bp_count: got %0d want %0d", issued_count, exp_count); end
    total++; if (obs_word_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_n_issued: got %0d want %0d", obs_word_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_word_q.size(); i++) begin
      total++; if (obs_word_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, obs_word_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal();
    int s0, i0;
    clear_logs();
    busy_cfg = 2;
    s0 = start_cycles;
    i0 = illegal_cycles;
    push(16'h0000);
    push(16'hC000);
    exp_count++;
    wait_idle();
    total++; if (illegal_cycles - i0 !== 1) begin bad++; $display("FAIL ill_pulses: got %0d want 1", illegal_cycles - i0); end
    total++; if (start_cycles - s0 !== 1) begin bad++; $display("FAIL ill_starts: got %0d want 1", start_cycles - s0); end
    total++; if (issued_count !== 8'(exp_count)) begin bad++; $display("FAIL ill_count: got %0d want %0d", issued_count, exp_count); end
    total++;
    if (obs_word_q.size() !== 1) begin
      bad++; $display("FAIL ill_issued: got %0d words want 1", obs_word_q.size());
    end else if (obs_word_q[0] !== 16'hC000) begin
      bad++; $display("FAIL ill_word: got %0h want c000", obs_word_q[0]);
    end
  endtask

  task automatic test_random();
    int s0, i0, e0, n_ill;
    logic [2:0]  op;
    logic [15:0] w;
    clear_logs();
    rand_busy = 1'b1;
    s0 = start_cycles;
    i0 = illegal_cycles;
    e0 = stable_err;
    n_ill = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
      else op = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6;
      w = {op, 13'($urandom)};
      push(w);
      if (ref_legal(w)) exp_count++;
      else n_ill++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    rand_busy = 1'b0;
    total++; if (illegal_cycles - i0 !== n_ill) begin bad++; $display("FAIL rnd_illegal: got %0d want %0d", illegal_cycles - i0, n_ill); end
    total++; if (start_cycles - s0 !== exp_q.size()) begin bad++; $display("FAIL rnd_starts: got %0d want %0d", start_cycles - s0, exp_q.size()); end
    total++; if (issued_count !== 8'(exp_count)) begin bad++; $display("FAIL rnd_count: got %0d want %0d", issued_count, exp_count); end
    total++; if (stable_err - e0 !== 0) begin bad++; $display("FAIL rnd_held: got %0d changes want 0", stable_err - e0); end
    total++; if (obs_word_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_n_issued: got %0d want %0d", obs_word_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_word_q.size(); i++) begin
      total++; if (obs_word_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_word[%0d]: got %0h want %0h", i, obs_word_q[i], exp_q[i]); end
      total++; if (obs_imm8_q[i] !== ref_sx8(exp_q[i])) begin bad++; $display("FAIL rnd_sximm8[%0d]: got %0h want %0h", i, obs_imm8_q[i], ref_sx8(exp_q[i])); end
      total++; if (obs_imm5_q[i] !== ref_sx5(exp_q[i])) begin bad++; $display("FAIL rnd_sximm5[%0d]: got %0h want %0h", i, obs_imm5_q[i], ref_sx5(exp_q[i])); end
    end
  endtask

  task automatic test_wrap();
    int s0, a0;
    clear_logs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    busy_cfg = 1;
    s0 = start_cycles;
    a0 = accepts;
    for (int k = 0; k < 256; k++) push({3'b110, 13'($urandom)});
    exp_count += 256;
    wait_idle();
    total++; if (issued_count !== 8'(exp_count)) begin bad++; $display("FAIL wrap_count: got %0h want %0h", issued_count, 8'(exp_count)); end
    total++; if (start_cycles - s0 !== 256) begin bad++; $display("FAIL wrap_starts: got %0d want 256", start_cycles - s0); end
    total++; if (accepts - a0 !== 256) begin bad++; $display("FAIL wrap_accepts: got %0d want 256", accepts - a0); end
  endtask

  initial begin
    test_reset();
    test_reset_traffic();
    test_add();
    test_mov();
    test_back_to_back();
    test_illegal();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue stage that sits directly upstream of the lab-6 `controller`. It buffers incoming 16-bit instructions in a small FIFO and latches one at a time into an instruction register (IR). It decodes the IR fields for the controller and datapath, and sequences the `start`/`waiting` handshake so that each legal instruction is issued exactly once. It also counts completed instructions and drops illegal opcodes.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, 2..8.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents `in_instr`.
- `in_instr`  in  16  instruction word.
- `in_ready`  out  1  FIFO can accept; equals (occupancy < DEPTH), combinational from registered occupancy only.
- `waiting`  in  1  from controller; 1 = controller idle in its wait state.
- `start`  out  1  to controller; equals (state==ISSUE) && `waiting`.
- `opcode`  out  3  IR[15:13].
- `ALU_op`  out  2  IR[12:11].
- `shift_op`  out  2  IR[4:3].
- `rn`, `rd`, `rm`  out  3 each  IR[10:8], IR[7:5], IR[2:0].
- `sximm8`  out  16  IR[7:0] sign-extended.
- `sximm5`  out  16  IR[4:0] sign-extended.
- `busy`  out  1  state != IDLE.
- `illegal`  out  1  one-cycle pulse when a popped instruction is dropped.
- `issued_count`  out  8  completed legal instructions, wraps 255 -> 0.

## Operation
- Push: at an edge where `in_valid` && `in_ready`, `in_instr` is written at the tail.
  - Push and pop in the same edge are both performed; occupancy is unchanged.
  - There is no bypass from input to IR.
- Legal opcodes are 3'b101 (ALU group) and 3'b110 (MOV group). All other opcodes are illegal.
- States:
  - IDLE
    - FIFO non-empty: pop the head into IR.
    - Popped opcode legal: go to ISSUE.
    - Popped opcode illegal: stay in IDLE and assert `illegal` for the next cycle. IR still loads, so decoded outputs show the dropped word.
  - ISSUE
    - `start` follows `waiting`.
    - At an edge with `waiting`=1, go to RUN; the controller has sampled `start` at that same edge.
  - RUN
    - Wait for an edge with `waiting`=0, then go to DONE_WAIT.
  - DONE_WAIT
    - At an edge with `waiting`=1: `issued_count` += 1.
    - Then, if the FIFO is non-empty, pop the next instruction with the same legality rule as IDLE: legal goes to ISSUE, illegal goes to IDLE and pulses `illegal`.
    - Otherwise go to IDLE.
- IR and all decoded outputs are registered. They hold stable from the pop until the next pop, covering every controller cycle of the instruction.
- Reset (asynchronous, any time, including mid-instruction):
  - FIFO empty; IR = 0; state IDLE.
  - `start`=0, `busy`=0, `illegal`=0, `issued_count`=0, `in_ready`=1.
  - Decoded outputs derive from IR=0, so all are 0.
  - An in-flight instruction is discarded and not counted.

## Timing
- With the FIFO empty and state IDLE:
  - Push at edge k.
  - Pop into IR at edge k+1.
  - `start` is high during cycle k+1..k+2 if `waiting`=1.
  - Controller samples `start` at edge k+2.
- `start` is high for exactly one cycle per instruction while the controller is waiting.
  - If `waiting`=0 on entering ISSUE, `start` stays low until `waiting` rises.
- Completion is counted one edge after the controller returns to wait.
  - A MOV-immediate (controller busy for 1 cycle) therefore occupies the issue stage for ISSUE(1) + RUN(1) + DONE_WAIT(1) cycles.
- A FIFO full at DEPTH keeps `in_ready`=0 during the cycle in which a pop occurs. `in_ready` rises the following cycle.
- An illegal drop costs one cycle. `illegal` is high only during the cycle after the drop edge.

## Test plan
- Reset with traffic:
  - Push 16'hA123.
  - Assert `rst` during RUN -> `start`=0, `busy`=0, `issued_count`=0, `in_ready`=1 immediately; nothing issued afterwards.
- Single ADD 16'b101_00_001_010_00_011:
  - Model the controller: `waiting` low for 4 cycles after `start`.
  - Expect `start` high exactly one cycle.
  - Expect `opcode`=101, `rn`=1, `rd`=2, `rm`=3 held through completion.
  - `issued_count`=1.
- MOVimm 16'hD2F0 (rn=2, imm8=F0):
  - Expect `sximm8`=16'hFFF0.
  - Controller busy 1 cycle -> count increments.
  - `busy` drops 3 cycles after `start`.
- Back-pressure with DEPTH=2 and the controller held busy:
  - Push 3 words -> `in_ready`=0 after the 2nd buffered word.
  - The 3rd word is accepted only after a pop.
  - All 3 words are issued in order.
- Illegal opcode:
  - Push 16'h0000, then 16'hC000 -> `illegal` pulses once and `issued_count` does not change for 16'h0000.
  - 16'hC000 then issues with `opcode`=110.
- Counter wrap:
  - Issue 256 MOVimm instructions -> `issued_count` returns to 8'h00.
  - `start` pulses equal 256.
